// File: rtl/clock_set_if.sv
// Key-pulse inputs and control outputs of the time-setting controller.
// master = key/1 Hz source and consumer of the controls, slave = the controller.
interface clock_set_if;
    logic       mode_btn;
    logic       up_btn;
    logic       clr_btn;
    logic       en1hz;
    logic       run;
    logic       carry_en;
    logic       sec_clr;
    logic       min_inc;
    logic       hour_inc;
    logic [1:0] mode;
    logic [5:0] blink_mask;

    modport master (
        output mode_btn, up_btn, clr_btn, en1hz,
        input  run, carry_en, sec_clr, min_inc, hour_inc, mode, blink_mask
    );

    modport slave (
        input  mode_btn, up_btn, clr_btn, en1hz,
        output run, carry_en, sec_clr, min_inc, hour_inc, mode, blink_mask
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer for the HH:MM:SS clock: mode FSM, set-mode timeout and
// digit blink. Every output comes straight from a flop.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   RUN      | normal timekeeping, seconds run, carries allowed
//   SET_HOUR | time frozen, up_btn bumps hours, hour digits blink
//   SET_MIN  | time frozen, up_btn bumps minutes, minute digits blink
//   ILLEGAL  | unreachable encoding, falls back to RUN
module clock_set_ctrl #(
    parameter int BLINK_CYC = 25_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic        clk,
    input  logic        rst,
    clock_set_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    localparam int BW = $clog2(BLINK_CYC);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYC - 1);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_S);

    state_t        state, state_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_ph, blink_ph_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          run_q, carry_q, sec_clr_q, min_inc_q, hour_inc_q;
    logic          sec_clr_n, min_inc_n, hour_inc_n;
    logic [5:0]    mask_q, mask_n;
    logic          key, up_act;

    always_comb begin
        state_n     = state;
        to_cnt_n    = to_cnt;
        blink_cnt_n = blink_cnt;
        blink_ph_n  = blink_ph;
        sec_clr_n   = bus.clr_btn;
        min_inc_n   = 1'b0;
        hour_inc_n  = 1'b0;
        up_act      = 1'b0;
        mask_n      = 6'b000000;
        key         = bus.mode_btn | bus.up_btn | bus.clr_btn;

        // mode_btn has priority, so up_btn in the same cycle is dropped
        case (state)
            RUN: begin
                if (bus.mode_btn) state_n = SET_HOUR;
            end
            SET_HOUR: begin
                if (bus.mode_btn) state_n = SET_MIN;
                else if (bus.up_btn) begin
                    hour_inc_n = 1'b1;
                    up_act     = 1'b1;
                end
            end
            SET_MIN: begin
                if (bus.mode_btn) state_n = RUN;
                else if (bus.up_btn) begin
                    min_inc_n = 1'b1;
                    up_act    = 1'b1;
                end
            end
            default: state_n = RUN;
        endcase

        // Keys beat en1hz; reaching the limit leaves SET, so the count never wraps
        if (state_n == RUN || state_n != state || key) begin
            to_cnt_n = '0;
        end else if (bus.en1hz) begin
            if (to_cnt >= TO_LIM - 1'b1) begin
                state_n  = RUN;
                to_cnt_n = '0;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end

        if (state_n == RUN || state_n != state || up_act) begin
            blink_cnt_n = '0;
            blink_ph_n  = 1'b0;
        end else if (blink_cnt == BLINK_TC) begin
            blink_cnt_n = '0;
            blink_ph_n  = ~blink_ph;
        end else begin
            blink_cnt_n = blink_cnt + 1'b1;
        end

        if (blink_ph_n) begin
            if (state_n == SET_HOUR)     mask_n = 6'b110000;
            else if (state_n == SET_MIN) mask_n = 6'b001100;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            to_cnt     <= '0;
            run_q      <= 1'b1;
            carry_q    <= 1'b1;
            sec_clr_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
            mask_q     <= 6'b000000;
        end else begin
            state      <= state_n;
            blink_cnt  <= blink_cnt_n;
            blink_ph   <= blink_ph_n;
            to_cnt     <= to_cnt_n;
            run_q      <= (state_n == RUN);
            carry_q    <= (state_n == RUN);
            sec_clr_q  <= sec_clr_n;
            min_inc_q  <= min_inc_n;
            hour_inc_q <= hour_inc_n;
            mask_q     <= mask_n;
        end
    end

    assign bus.mode       = state;
    assign bus.run        = run_q;
    assign bus.carry_en   = carry_q;
    assign bus.sec_clr    = sec_clr_q;
    assign bus.min_inc    = min_inc_q;
    assign bus.hour_inc   = hour_inc_q;
    assign bus.blink_mask = mask_q;

endmodule
